// File: rtl/serial_borrow_subtractor_if.sv
// Handshake and result bundle for the bit-serial borrow subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_borrow_subtractor_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial a - b - bin using one full-subtractor cell, LSB first.
// Result (done pulse) WIDTH+1 cycles after an accepted start; start is ignored while busy.
module serial_borrow_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  serial_borrow_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_br_n;
  logic w_accept;
  logic w_last;
  logic w_busy;
  logic w_done;

  assign w_ai     = r_a_sr[0];
  assign w_bi     = r_b_sr[0];
  assign w_d      = w_ai ^ w_bi ^ r_borrow;
  assign w_br_n   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_accept = bus.start && (r_state != S_SHIFT);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_SHIFT: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Capture is legal from IDLE and DONE, which is what gives back-to-back issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_borrow <= bus.bin;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_borrow <= w_br_n;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_bout <= w_br_n;
      end
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed and random checks of the serial subtractor against an integer-arithmetic model.
module tb_serial_borrow_subtractor;
  localparam int WIDTH = 6;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  serial_borrow_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_borrow_subtractor #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
  } op_t;

  op_t q[$];

  // {bout, diff}: plain signed subtraction, borrow is simply "went negative".
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {(r < 0), r[WIDTH-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one op; optionally fire a competing start on SHIFT cycle glitch (0-based).
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, b, input logic bin,
                       input int glitch);
    logic [WIDTH:0] exp;
    int cyc;
    int nb;
    exp = ref_sub(a, b, bin);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(negedge clk);
    cyc = 0; nb = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) nb++;
      bus.start = (cyc == glitch);
      if (cyc == glitch) begin
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.bin = 1'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp[WIDTH-1:0]));
    check({tag, "_bout"}, 32'(bus.bout), 32'(exp[WIDTH]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_diff_hold"}, 32'(bus.diff), 32'(exp[WIDTH-1:0]));
  endtask

  initial begin
    logic [WIDTH:0] exp;
    op_t op;
    int  got;
    int  gap;
    int  guard;
    int  seen_done;
    bit  first;

    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;

    do_op("t1_10m3", 6'd10, 6'd3, 1'b0, -1);
    do_op("t2_3m10", 6'd3, 6'd10, 1'b0, -1);
    do_op("t2_0m0b", 6'd0, 6'd0, 1'b1, -1);
    do_op("t3_63m63", 6'd63, 6'd63, 1'b0, -1);
    do_op("t3_63m0b", 6'd63, 6'd0, 1'b1, -1);
    do_op("t4_ignore", 6'd20, 6'd5, 1'b1, 2);

    // Reset in the middle of SHIFT aborts with no done pulse.
    @(negedge clk);
    bus.a = 6'd45; bus.b = 6'd17; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_diff", 32'(bus.diff), 32'd0);
    check("t5_bout", 32'(bus.bout), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("t5_no_done", 32'(seen_done), 32'd0);

    // Start held high: one result every WIDTH+1 cycles, random operands.
    op.a = WIDTH'($urandom); op.b = WIDTH'($urandom); op.bin = 1'($urandom);
    bus.a = op.a; bus.b = op.b; bus.bin = op.bin; bus.start = 1'b1;
    q.push_back(op);
    got = 0; gap = 0; guard = 0; first = 1'b1;
    while (got < 200 && guard < 3000) begin
      @(negedge clk);
      guard++; gap++;
      if (bus.done) begin
        op = q.pop_front();
        exp = ref_sub(op.a, op.b, op.bin);
        check("t6_diff", 32'(bus.diff), 32'(exp[WIDTH-1:0]));
        check("t6_bout", 32'(bus.bout), 32'(exp[WIDTH]));
        if (!first) check("t6_period", 32'(gap), 32'(WIDTH + 1));
        first = 1'b0;
        gap = 0;
        got++;
        if (got < 200) begin
          op.a = WIDTH'($urandom); op.b = WIDTH'($urandom); op.bin = 1'($urandom);
          bus.a = op.a; bus.b = op.b; bus.bin = op.bin;
          q.push_back(op);
        end else begin
          bus.start = 1'b0;
        end
      end else if (bus.busy) begin
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.bin = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    check("t6_ops_done", 32'(got), 32'd200);
    @(negedge clk);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
